// File: rtl/edge_count_scheduler.sv
// edge_count_scheduler: one saturating falling-edge counter shared round-robin across N_CH inputs
module edge_count_scheduler #(
    parameter int N_CH   = 4,
    parameter int WINDOW = 1000,
    parameter int CNT_W  = 8,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_CH-1:0]  i_signal_in,
    input  logic [N_CH-1:0]  i_ch_mask,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic [CH_W-1:0]  o_result_ch,
    output logic [CNT_W-1:0] o_result_count,
    output logic             o_result_sat
);
    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_COUNT, S_REPORT} state_t;
    state_t           r_state;
    logic [N_CH-1:0]  r_sync1, r_sync2, r_hist, r_mask;
    logic [CH_W-1:0]  r_last_ch, r_cur_ch;
    logic [CNT_W-1:0] r_count;
    logic [WIN_W-1:0] r_win;
    logic             r_sat, r_busy, r_valid;
    logic [N_CH-1:0]  w_fall;
    logic [CH_W-1:0]  w_sel, w_idx;
    logic             w_found, w_hit, w_last_win;
    assign w_fall         = r_hist & ~r_sync2;
    assign w_hit          = w_fall[r_cur_ch];
    assign w_last_win     = r_win == WIN_W'(WINDOW - 1);
    assign o_busy         = r_busy;
    assign o_result_valid = r_valid;
    assign o_result_ch    = r_cur_ch;
    assign o_result_count = r_count;
    assign o_result_sat   = r_sat;
    // Two-flop synchronizer plus history flop per channel for falling-edge detection
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= i_signal_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end
    // Round-robin pick: first pending channel strictly after the last one served
    always_comb begin
        w_idx   = r_last_ch;
        w_sel   = r_last_ch;
        w_found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            w_idx = (w_idx == CH_W'(N_CH - 1)) ? '0 : w_idx + 1'b1;
            if (!w_found && r_mask[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end
    // Sweep sequencer: select channel, gate for WINDOW clocks, hold result until accepted
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_last_ch <= CH_W'(N_CH - 1);
            r_cur_ch  <= '0;
            r_count   <= '0;
            r_sat     <= 1'b0;
            r_win     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start && |i_ch_mask) begin
                    r_mask  <= i_ch_mask;
                    r_busy  <= 1'b1;
                    r_state <= S_SELECT;
                end
                S_SELECT: begin
                    r_cur_ch      <= w_sel;
                    r_mask[w_sel] <= 1'b0;
                    r_count       <= '0;
                    r_sat         <= 1'b0;
                    r_win         <= '0;
                    r_state       <= S_COUNT;
                end
                S_COUNT: begin
                    r_count <= r_count + CNT_W'(w_hit && !(&r_count));
                    r_sat   <= r_sat | (w_hit & (&r_count));
                    r_win   <= r_win + 1'b1;
                    r_valid <= w_last_win;
                    r_state <= w_last_win ? S_REPORT : S_COUNT;
                end
                S_REPORT: if (i_result_ready) begin
                    r_last_ch <= r_cur_ch;
                    r_valid   <= 1'b0;
                    r_busy    <= |r_mask;
                    r_state   <= |r_mask ? S_SELECT : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_edge_count_scheduler.sv
// tb_edge_count_scheduler: randomized scoreboard bench for the round-robin edge counter
module tb_edge_count_scheduler;
    localparam int N = 4, W = 16, CW = 8, CHW = 2, MAXV = 255, MAXC = 20000;
    typedef struct packed {logic [CHW-1:0] ch; logic [CW-1:0] cnt; logic sat;} res_t;
    logic clk = 1'b0, reset = 1'b1;
    logic [N-1:0] sig = '1, nxt_sig, ch_mask = '0;
    logic start = 1'b0, ready = 1'b0, busy, valid, rsat;
    logic [CHW-1:0] rch;
    logic [CW-1:0] rcnt;
    logic [N-1:0] s_sig = '1;
    logic s_start = 1'b0, s_ready = 1'b1, s_busy, s_valid, s_sat;
    logic [CHW-1:0] s_ch;
    logic [2:0] s_cnt;
    int tests = 0, fails = 0, cyc = 0, model_last = N - 1, held_val;
    bit rand_en = 1'b0, held_v = 1'b0;
    bit fall_log [MAXC][N];
    res_t q[$];
    res_t mon_exp;

    edge_count_scheduler #(.N_CH(N), .WINDOW(W), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(reset), .i_signal_in(sig), .i_ch_mask(ch_mask), .i_start(start),
        .o_busy(busy), .o_result_valid(valid), .i_result_ready(ready),
        .o_result_ch(rch), .o_result_count(rcnt), .o_result_sat(rsat));

    edge_count_scheduler #(.N_CH(N), .WINDOW(64), .CNT_W(3)) dut_sat (
        .i_clk(clk), .i_reset(reset), .i_signal_in(s_sig), .i_ch_mask(4'b0001), .i_start(s_start),
        .o_busy(s_busy), .o_result_valid(s_valid), .i_result_ready(s_ready),
        .o_result_ch(s_ch), .o_result_count(s_cnt), .o_result_sat(s_sat));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Random pin activity; each fall is logged against the cycle in which the pin dropped
    always @(posedge clk) begin
        #2;
        nxt_sig = rand_en ? N'($urandom) : '1;
        for (int c = 0; c < N; c++) if (cyc < MAXC) fall_log[cyc][c] = sig[c] & ~nxt_sig[c];
        sig = nxt_sig;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks hold stability while stalled and pops the scoreboard on each handshake
    always @(negedge clk) begin
        if (!reset && valid) begin
            if (held_v) check("hold_stable", int'({rch, rcnt, rsat}), held_val);
            if (ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got ch=%0d count=%0d required none", rch, rcnt);
                end else begin
                    mon_exp = q.pop_front();
                    check("res_ch", int'(rch), int'(mon_exp.ch));
                    check("res_count", int'(rcnt), int'(mon_exp.cnt));
                    check("res_sat", int'(rsat), int'(mon_exp.sat));
                end
                held_v = 1'b0;
            end else begin
                held_val = int'({rch, rcnt, rsat});
                held_v   = 1'b1;
            end
        end else held_v = 1'b0;
    end

    task automatic sweep(input logic [N-1:0] m, input int stall, input bit noise);
        int order[$];
        int r, n, wait_n;
        res_t e;
        for (int d = 1; d <= N; d++) if (m[(model_last + d) % N]) order.push_back((model_last + d) % N);
        ch_mask = m;
        start   = 1'b1;
        tick();
        r       = cyc;
        start   = noise;
        ch_mask = noise ? N'($urandom) : m;
        check("busy_start", int'(busy), 1);
        foreach (order[s]) begin
            ready = (stall == 0);
            while (cyc < r + W) tick();
            check("valid_early", int'(valid), 0);
            n = 0;
            for (int k = r - 1; k <= r + W - 2; k++) n += int'(fall_log[k][order[s]]);
            e.ch  = CHW'(order[s]);
            e.cnt = CW'(n > MAXV ? MAXV : n);
            e.sat = n > MAXV;
            q.push_back(e);
            tick();
            check("valid_rise", int'(valid), 1);
            repeat (stall) tick();
            ready  = 1'b1;
            wait_n = 0;
            while (!(valid && ready) && wait_n < 50) begin
                tick();
                wait_n++;
            end
            if (!(valid && ready)) begin
                tests++;
                fails++;
                $display("FAIL handshake_timeout: no result for ch %0d", order[s]);
                start = 1'b0;
                return;
            end
            tick();
            r = cyc;
            model_last = order[s];
        end
        check("busy_end", int'(busy), 0);
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        #1;
        repeat (2) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_ch", int'(rch), 0);
        check("rst_count", int'(rcnt), 0);
        check("rst_sat", int'(rsat), 0);
        reset   = 1'b0;
        rand_en = 1'b1;
        repeat (3) tick();
        ch_mask = '0;
        start   = 1'b1;
        tick();
        check("zero_mask_busy", int'(busy), 0);
        start = 1'b0;
        tick();
        check("zero_mask_busy2", int'(busy), 0);
        check("zero_mask_valid", int'(valid), 0);
        sweep(4'b0001, 0, 1'b0);
        sweep(4'b1011, 0, 1'b1);
        sweep(4'b1110, 5, 1'b0);
        sweep(4'b0001, 0, 1'b0);
        ch_mask = '1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_ch", int'(rch), 0);
        check("midrst_count", int'(rcnt), 0);
        check("midrst_sat", int'(rsat), 0);
        reset      = 1'b0;
        model_last = N - 1;
        repeat (3) tick();
        sweep(4'b1111, 0, 1'b0);
        for (int i = 0; i < 8; i++) sweep(N'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        repeat (30) tick();
        check("queue_empty", q.size(), 0);
        check("idle_valid", int'(valid), 0);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int j = 0; j < 10; j++) begin
            s_sig[0] = 1'b0;
            tick();
            s_sig[0] = 1'b1;
            tick();
        end
        w = 0;
        while (!s_valid && w < 100) begin
            tick();
            w++;
        end
        check("sat_valid", int'(s_valid), 1);
        check("sat_ch", int'(s_ch), 0);
        check("sat_count", int'(s_cnt), 7);
        check("sat_flag", int'(s_sat), 1);
        tick();
        check("sat_busy_end", int'(s_busy), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
